// File: rtl/rv_pipe_pkg.sv
// Shared pipeline-control types: MDU FSM encoding, default widths/latencies,
// and the hazard priority-row identifiers used by the controller and its perf counters.
package rv_pipe_pkg;

    localparam int unsigned REG_AW_DEFAULT  = 5;
    localparam int unsigned DIV_LAT_DEFAULT = 32;
    localparam int unsigned CNT_W           = 8;

    typedef enum logic {
        IDLE     = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    typedef enum logic [2:0] {
        ROW_NONE     = 3'd0,
        ROW_MEMSTALL = 3'd1,
        ROW_MDUSTALL = 3'd2,
        ROW_BRANCH   = 3'd3,
        ROW_LOADUSE  = 3'd4,
        ROW_JAL      = 3'd5
    } hazard_row_e;

    // Highest-priority hazard wins; exactly one row drives the strobes.
    function automatic hazard_row_e select_row(
        input logic memstall,
        input logic mdustall,
        input logic br_taken,
        input logic loaduse,
        input logic jal
    );
        if (memstall)      return ROW_MEMSTALL;
        else if (mdustall) return ROW_MDUSTALL;
        else if (br_taken) return ROW_BRANCH;
        else if (loaduse)  return ROW_LOADUSE;
        else if (jal)      return ROW_JAL;
        else               return ROW_NONE;
    endfunction

endpackage

// File: rtl/mdu_stall_counter.sv
// Divide-occupancy tracker: holds EX for DIV_LAT cycles per divide and pulses
// done on the release cycle. freeze (memory wait) holds both state and count.
module mdu_stall_counter
    import rv_pipe_pkg::*;
#(
    parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic freeze,
    output logic stall,
    output logic done
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    stall = 1'b1;
                    if (!freeze) begin
                        state_d = MDU_BUSY;
                        cnt_d   = CNT_W'(DIV_LAT - 1);
                    end
                end
            end
            MDU_BUSY: begin
                // start is ignored here so the held divide never re-arms.
                if (cnt_q != '0) begin
                    stall = 1'b1;
                    if (!freeze) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else if (!freeze) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: bubble/flush strobes for F/D/E/M/W from a fixed
// priority of memory wait, divide occupancy, taken branch, load-use and JAL.
// Optional perf counters are enabled with `define HAZARD_PERF_EN.
module hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT,
    parameter int unsigned REG_AW  = REG_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic              rs1_usedD,
    input  logic              rs2_usedD,
    input  logic [REG_AW-1:0] rdE,
    input  logic              memreadE,
    input  logic              jalD,
    input  logic              br_takenE,
    input  logic              div_startE,
    input  logic              dmem_reqM,
    input  logic              dmem_readyM,
    output logic              bubbleF,
    output logic              bubbleD,
    output logic              bubbleE,
    output logic              bubbleM,
    output logic              bubbleW,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              mdu_done
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_loaduse,
    output logic [31:0]       perf_flush,
    output logic [31:0]       perf_memwait,
    output logic [31:0]       perf_mduwait
`endif
);

    logic        memstall;
    logic        loaduse;
    logic        mdustall;
    logic        div_done;
    hazard_row_e row;

    assign memstall = dmem_reqM & ~dmem_readyM;
    assign loaduse  = memreadE & (rdE != '0) &
                      ((rs1_usedD & (rdE == rs1D)) | (rs2_usedD & (rdE == rs2D)));
    assign row      = select_row(memstall, mdustall, br_takenE, loaduse, jalD);

    mdu_stall_counter #(
        .DIV_LAT (DIV_LAT)
    ) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (div_startE),
        .freeze (memstall),
        .stall  (mdustall),
        .done   (div_done)
    );

    always_comb begin
        bubbleF  = 1'b0;
        bubbleD  = 1'b0;
        bubbleE  = 1'b0;
        bubbleM  = 1'b0;
        bubbleW  = 1'b0;
        flushD   = 1'b0;
        flushE   = 1'b0;
        flushM   = 1'b0;
        flushW   = 1'b0;
        mdu_done = 1'b0;
        // Reset zeroes every pipeline register regardless of pending hazards.
        if (!rst_n) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end else begin
            mdu_done = div_done;
            case (row)
                ROW_MEMSTALL: begin
                    bubbleF = 1'b1;
                    bubbleD = 1'b1;
                    bubbleE = 1'b1;
                    bubbleM = 1'b1;
                    flushW  = 1'b1;
                end
                ROW_MDUSTALL: begin
                    bubbleF = 1'b1;
                    bubbleD = 1'b1;
                    bubbleE = 1'b1;
                    flushM  = 1'b1;
                end
                ROW_BRANCH: begin
                    flushD = 1'b1;
                    flushE = 1'b1;
                end
                ROW_LOADUSE: begin
                    bubbleF = 1'b1;
                    bubbleD = 1'b1;
                    flushE  = 1'b1;
                end
                ROW_JAL: begin
                    flushD = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_loaduse_q, perf_loaduse_d;
    logic [31:0] perf_flush_q,   perf_flush_d;
    logic [31:0] perf_memwait_q, perf_memwait_d;
    logic [31:0] perf_mduwait_q, perf_mduwait_d;

    always_comb begin
        perf_loaduse_d = perf_loaduse_q;
        perf_flush_d   = perf_flush_q;
        perf_memwait_d = perf_memwait_q;
        perf_mduwait_d = perf_mduwait_q;
        case (row)
            ROW_LOADUSE:          perf_loaduse_d = perf_loaduse_q + 32'd1;
            ROW_BRANCH, ROW_JAL:  perf_flush_d   = perf_flush_q + 32'd1;
            ROW_MEMSTALL:         perf_memwait_d = perf_memwait_q + 32'd1;
            ROW_MDUSTALL:         perf_mduwait_d = perf_mduwait_q + 32'd1;
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_loaduse_q <= '0;
            perf_flush_q   <= '0;
            perf_memwait_q <= '0;
            perf_mduwait_q <= '0;
        end else begin
            perf_loaduse_q <= perf_loaduse_d;
            perf_flush_q   <= perf_flush_d;
            perf_memwait_q <= perf_memwait_d;
            perf_mduwait_q <= perf_mduwait_d;
        end
    end

    assign perf_loaduse = perf_loaduse_q;
    assign perf_flush   = perf_flush_q;
    assign perf_memwait = perf_memwait_q;
    assign perf_mduwait = perf_mduwait_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (DIV_LAT=4): expected strobe vectors are queued
// when stimulus is driven and compared on the following falling edge.
module tb_hazard_ctrl;

    localparam int DIV_LAT = 4;

    // Strobe vector order: {bF,bD,bE,bM,bW, fD,fE,fM,fW, mdu_done}
    localparam logic [9:0] EXP_NONE = 10'b00000_0000_0;
    localparam logic [9:0] EXP_LU   = 10'b11000_0100_0;
    localparam logic [9:0] EXP_BR   = 10'b00000_1100_0;
    localparam logic [9:0] EXP_MDU  = 10'b11100_0010_0;
    localparam logic [9:0] EXP_MEM  = 10'b11110_0001_0;
    localparam logic [9:0] EXP_JAL  = 10'b00000_1000_0;
    localparam logic [9:0] EXP_DONE = 10'b00000_0000_1;
    localparam logic [9:0] EXP_RST  = 10'b00000_1111_0;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       jal;
        logic       br;
        logic       div;
        logic       req;
        logic       rdy;
    } stim_t;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1D, rs2D, rdE;
    logic       rs1_usedD, rs2_usedD, memreadE, jalD, br_takenE, div_startE;
    logic       dmem_reqM, dmem_readyM;
    logic       bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
    logic       flushD, flushE, flushM, flushW, mdu_done;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_loaduse, perf_flush, perf_memwait, perf_mduwait;
`endif

    int         errors = 0;
    int         checks = 0;
    logic [9:0] expQ[$];
    string      tagQ[$];
    logic [9:0] obs;

    assign obs = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
                  flushD, flushE, flushM, flushW, mdu_done};

    hazard_ctrl #(
        .DIV_LAT (DIV_LAT),
        .REG_AW  (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1D        (rs1D),
        .rs2D        (rs2D),
        .rs1_usedD   (rs1_usedD),
        .rs2_usedD   (rs2_usedD),
        .rdE         (rdE),
        .memreadE    (memreadE),
        .jalD        (jalD),
        .br_takenE   (br_takenE),
        .div_startE  (div_startE),
        .dmem_reqM   (dmem_reqM),
        .dmem_readyM (dmem_readyM),
        .bubbleF     (bubbleF),
        .bubbleD     (bubbleD),
        .bubbleE     (bubbleE),
        .bubbleM     (bubbleM),
        .bubbleW     (bubbleW),
        .flushD      (flushD),
        .flushE      (flushE),
        .flushM      (flushM),
        .flushW      (flushW),
        .mdu_done    (mdu_done)
`ifdef HAZARD_PERF_EN
        ,
        .perf_loaduse (perf_loaduse),
        .perf_flush   (perf_flush),
        .perf_memwait (perf_memwait),
        .perf_mduwait (perf_mduwait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic drainScoreboard();
        while (expQ.size() > 0) begin
            checkOutput(tagQ.pop_front(), {22'b0, obs}, {22'b0, expQ.pop_front()});
        end
    endtask

    task automatic driveInputs(input stim_t s, input logic rstVal);
        rst_n       = rstVal;
        rs1D        = s.rs1;
        rs2D        = s.rs2;
        rs1_usedD   = s.u1;
        rs2_usedD   = s.u2;
        rdE         = s.rd;
        memreadE    = s.mr;
        jalD        = s.jal;
        br_takenE   = s.br;
        div_startE  = s.div;
        dmem_reqM   = s.req;
        dmem_readyM = s.rdy;
    endtask

    // One cycle: drive just after the rising edge, compare on the falling edge.
    task automatic applyStimulus(input string tag, input stim_t s, input logic rstVal, input logic [9:0] exp);
        @(posedge clk);
        #1;
        driveInputs(s, rstVal);
        expQ.push_back(exp);
        tagQ.push_back(tag);
        @(negedge clk);
        drainScoreboard();
    endtask

    function automatic stim_t sIdle();
        stim_t s;
        s     = '0;
        s.rdy = 1'b1;
        return s;
    endfunction

    function automatic stim_t sLoadUse(input logic [4:0] rd, input logic [4:0] rs1);
        stim_t s;
        s     = sIdle();
        s.mr  = 1'b1;
        s.rd  = rd;
        s.rs1 = rs1;
        s.u1  = 1'b1;
        return s;
    endfunction

    function automatic stim_t sDiv();
        stim_t s;
        s     = sIdle();
        s.div = 1'b1;
        return s;
    endfunction

    initial begin
        stim_t s;
        driveInputs(sIdle(), 1'b0);

        // Reset dominates any pending hazard.
        applyStimulus("reset_idle", sIdle(), 1'b0, EXP_RST);
        applyStimulus("reset_lu", sLoadUse(5'd5, 5'd5), 1'b0, EXP_RST);
        applyStimulus("post_reset", sIdle(), 1'b1, EXP_NONE);

        // Load-use on rs1, then rs2; x0 destination and unused rs2 never stall.
        applyStimulus("lu_rs1", sLoadUse(5'd5, 5'd5), 1'b1, EXP_LU);
        applyStimulus("lu_release", sIdle(), 1'b1, EXP_NONE);
        applyStimulus("lu_x0", sLoadUse(5'd0, 5'd0), 1'b1, EXP_NONE);
        applyStimulus("lu_nomatch", sLoadUse(5'd7, 5'd5), 1'b1, EXP_NONE);
        s = sLoadUse(5'd9, 5'd1);
        s.rs2 = 5'd9;
        applyStimulus("lu_rs2_unused", s, 1'b1, EXP_NONE);
        s.u2 = 1'b1;
        applyStimulus("lu_rs2", s, 1'b1, EXP_LU);

        // Branch beats load-use and JAL; load-use beats JAL.
        s = sLoadUse(5'd5, 5'd5);
        s.br = 1'b1;
        applyStimulus("br_over_lu", s, 1'b1, EXP_BR);
        s = sIdle();
        s.jal = 1'b1;
        applyStimulus("jal", s, 1'b1, EXP_JAL);
        s = sLoadUse(5'd3, 5'd3);
        s.jal = 1'b1;
        applyStimulus("lu_over_jal", s, 1'b1, EXP_LU);
        s = sIdle();
        s.jal = 1'b1;
        s.br  = 1'b1;
        applyStimulus("br_over_jal", s, 1'b1, EXP_BR);

        // Memory wait defers a branch until the access completes.
        s = sIdle();
        s.br  = 1'b1;
        s.req = 1'b1;
        s.rdy = 1'b0;
        applyStimulus("mem_defers_br", s, 1'b1, EXP_MEM);
        s.rdy = 1'b1;
        applyStimulus("br_after_mem", s, 1'b1, EXP_BR);

        // Plain divide: DIV_LAT stall cycles then a done pulse.
        for (int i = 0; i < DIV_LAT; i++) applyStimulus("div_stall", sDiv(), 1'b1, EXP_MDU);
        applyStimulus("div_done", sDiv(), 1'b1, EXP_DONE);
        applyStimulus("div_idle", sIdle(), 1'b1, EXP_NONE);

        // Memory wait with cnt=2 freezes the divide for three cycles.
        applyStimulus("dm_stall0", sDiv(), 1'b1, EXP_MDU);
        applyStimulus("dm_stall1", sDiv(), 1'b1, EXP_MDU);
        s = sDiv();
        s.req = 1'b1;
        s.rdy = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus("dm_memwait", s, 1'b1, EXP_MEM);
        applyStimulus("dm_stall2", sDiv(), 1'b1, EXP_MDU);
        applyStimulus("dm_stall3", sDiv(), 1'b1, EXP_MDU);
        applyStimulus("dm_done", sDiv(), 1'b1, EXP_DONE);

        // Back-to-back divide, with a memory wait landing on the release cycle.
        for (int i = 0; i < DIV_LAT; i++) applyStimulus("b2b_stall", sDiv(), 1'b1, EXP_MDU);
        applyStimulus("b2b_mem_at_zero", s, 1'b1, EXP_MEM);
        applyStimulus("b2b_done", sDiv(), 1'b1, EXP_DONE);
        applyStimulus("b2b_idle", sIdle(), 1'b1, EXP_NONE);

        // Reset with cnt=1 aborts the divide without a done pulse.
        for (int i = 0; i < 3; i++) applyStimulus("rd_stall", sDiv(), 1'b1, EXP_MDU);
        applyStimulus("rd_reset", sDiv(), 1'b0, EXP_RST);
        for (int i = 0; i < DIV_LAT + 2; i++) applyStimulus("rd_no_done", sIdle(), 1'b1, EXP_NONE);
        applyStimulus("rd_restart", sDiv(), 1'b1, EXP_MDU);
        applyStimulus("rd_reset2", sIdle(), 1'b0, EXP_RST);

`ifdef HAZARD_PERF_EN
        applyStimulus("perf_release", sIdle(), 1'b1, EXP_NONE);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("perf_lu", sLoadUse(5'd4, 5'd4), 1'b1, EXP_LU);
            applyStimulus("perf_gap", sIdle(), 1'b1, EXP_NONE);
        end
        s = sIdle();
        s.jal = 1'b1;
        for (int i = 0; i < 2; i++) applyStimulus("perf_jal", s, 1'b1, EXP_JAL);
        applyStimulus("perf_settle", sIdle(), 1'b1, EXP_NONE);
        checkOutput("perf_loaduse", perf_loaduse, 32'd3);
        checkOutput("perf_flush", perf_flush, 32'd2);
        checkOutput("perf_memwait", perf_memwait, 32'd0);
        checkOutput("perf_mduwait", perf_mduwait, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
